// File: rtl/irq_event_logger_pkg.sv
// irq_event_logger_pkg: definitions shared by the interrupt event logger.
//   - Avalon word addresses of the eight logger registers
//   - bit positions inside the STATUS and CONTROL registers
//   - entry_t, one FIFO entry: source bitmap plus 32-bit capture timestamp
package irq_event_logger_pkg;

    localparam logic [2:0] ADDR_STATUS    = 3'd0;
    localparam logic [2:0] ADDR_CONTROL   = 3'd1;
    localparam logic [2:0] ADDR_HEAD_SRC  = 3'd2;
    localparam logic [2:0] ADDR_HEAD_TS_L = 3'd3;
    localparam logic [2:0] ADDR_HEAD_TS_H = 3'd4;
    localparam logic [2:0] ADDR_POP       = 3'd5;
    localparam logic [2:0] ADDR_NOW_L     = 3'd6;
    localparam logic [2:0] ADDR_NOW_H     = 3'd7;

    localparam int STATUS_NOT_EMPTY = 0;
    localparam int STATUS_FULL      = 1;
    localparam int STATUS_OVF       = 2;
    localparam int STATUS_COUNT_LSB = 8;

    localparam int CONTROL_IRQ_EN   = 8;
    localparam int CONTROL_FLUSH    = 9;

    typedef struct packed {
        logic [7:0]  src;
        logic [31:0] ts;
    } entry_t;

endpackage

// File: rtl/event_fifo.sv
// event_fifo: synchronous show-ahead FIFO of logger entries.
//   clk, reset_n : clock and asynchronous active-low reset
//   push, din    : write one entry (dropped when full unless popping too)
//   pop          : discard the head entry (ignored when empty)
//   flush        : empty the FIFO; overrides push and pop
//   head         : current oldest entry, valid whenever empty is low
//   count        : number of stored entries (0..DEPTH)
//   full, empty  : occupancy flags
module event_fifo
    import irq_event_logger_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  entry_t                 din,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a
    // push that coincides with a pop.
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | pop) & ~flush;

    // Entry storage; no reset needed because empty masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
    // pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_event_logger.sv
// irq_event_logger: timestamps rising edges of interval-timer interrupts.
//   clk, reset_n            : clock and asynchronous active-low reset
//   chipselect, address,
//   read_n, write_n,
//   writedata, readdata     : 16-bit Avalon-MM slave, readdata registered
//   irq_in[NUM_SRC]         : level interrupt lines from the timers
//   irq                     : logger interrupt, irq_en & FIFO not empty
module irq_event_logger
    import irq_event_logger_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int TS_WIDTH   = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               chipselect,
    input  logic [2:0]         address,
    input  logic               read_n,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_SRC-1:0] irq_in,
    output logic               irq
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [TS_WIDTH-1:0] timestamp;
    logic [NUM_SRC-1:0]  irq_dly;
    logic [NUM_SRC-1:0]  enable_mask;
    logic [NUM_SRC-1:0]  edge_vec;
    logic                irq_en;
    logic                overflow;
    logic [15:0]         now_h_shadow;
    logic                bus_wr;
    logic                bus_rd;
    logic                ctrl_wr;
    logic                do_flush;
    logic                do_pop;
    logic                ovf_clr;
    logic                ovf_set;
    logic                push_req;
    entry_t              push_entry;
    entry_t              head;
    logic [CNT_W-1:0]    count;
    logic                full;
    logic                empty;
    logic [15:0]         read_mux;
    logic                unused_writedata;

    assign bus_wr   = chipselect & ~write_n;
    assign bus_rd   = chipselect & ~read_n;
    assign ctrl_wr  = bus_wr & (address == ADDR_CONTROL);
    assign do_flush = ctrl_wr & writedata[CONTROL_FLUSH];
    assign do_pop   = bus_wr & (address == ADDR_POP);
    assign ovf_clr  = bus_wr & (address == ADDR_STATUS);

    // irq_dly follows the raw lines, so a source enabled while already high
    // produces no event until it falls and rises again.
    assign edge_vec = irq_in & ~irq_dly & enable_mask;
    assign push_req = |edge_vec;

    // A dropped event only counts as overflow when nothing makes room for it
    // and the FIFO is not being flushed in the same cycle.
    assign ovf_set  = push_req & full & ~do_pop & ~do_flush;

    assign irq      = irq_en & ~empty;

    assign unused_writedata = ^writedata;

    // Build the entry: source bitmap zero-extended to 8 bits, stamped with
    // the timestamp of the cycle in which the edge is seen.
    always_comb begin
        push_entry = '0;
        push_entry.src[NUM_SRC-1:0] = edge_vec;
        push_entry.ts = timestamp;
    end

    event_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (push_req),
        .pop    (do_pop),
        .flush  (do_flush),
        .din    (push_entry),
        .head   (head),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    // Free-running timestamp and the one-cycle delayed copy of the irq lines.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timestamp <= '0;
            irq_dly   <= '0;
        end else begin
            timestamp <= timestamp + 1'b1;
            irq_dly   <= irq_in;
        end
    end

    // Software-visible state: control bits, sticky overflow and the NOW_H
    // shadow. Overflow set beats a clear in the same cycle; the shadow
    // keeps the upper half coherent with the NOW_L read that captured it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_mask  <= '0;
            irq_en       <= 1'b0;
            overflow     <= 1'b0;
            now_h_shadow <= '0;
        end else begin
            if (ctrl_wr) begin
                enable_mask <= writedata[NUM_SRC-1:0];
                irq_en      <= writedata[CONTROL_IRQ_EN];
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            if (bus_rd && (address == ADDR_NOW_L)) begin
                now_h_shadow <= timestamp[31:16];
            end
        end
    end

    // Register read multiplexer; head fields read 0 while the FIFO is empty.
    always_comb begin
        read_mux = '0;
        case (address)
            ADDR_STATUS: begin
                read_mux[STATUS_NOT_EMPTY]            = ~empty;
                read_mux[STATUS_FULL]                 = full;
                read_mux[STATUS_OVF]                  = overflow;
                read_mux[STATUS_COUNT_LSB +: CNT_W]   = count;
            end
            ADDR_CONTROL: begin
                read_mux[NUM_SRC-1:0]    = enable_mask;
                read_mux[CONTROL_IRQ_EN] = irq_en;
            end
            ADDR_HEAD_SRC: begin
                if (!empty) read_mux[7:0] = head.src;
            end
            ADDR_HEAD_TS_L: begin
                if (!empty) read_mux = head.ts[15:0];
            end
            ADDR_HEAD_TS_H: begin
                if (!empty) read_mux = head.ts[31:16];
            end
            ADDR_NOW_L: read_mux = timestamp[15:0];
            ADDR_NOW_H: read_mux = now_h_shadow;
            default:    read_mux = '0;
        endcase
    end

    // readdata is registered every cycle: one clock of read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= read_mux;
        end
    end

endmodule

// File: tb/tb_irq_event_logger.sv
// tb_irq_event_logger: self-checking bench for irq_event_logger.
// A queue-based reference model predicts readdata and irq every cycle;
// directed sequences and a register vector table add fixed expectations.
module tb_irq_event_logger;

    localparam int NUM_SRC    = 4;
    localparam int FIFO_DEPTH = 16;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               chipselect;
    logic [2:0]         address;
    logic               read_n;
    logic               write_n;
    logic [15:0]        writedata;
    logic [15:0]        readdata;
    logic [NUM_SRC-1:0] irq_in;
    logic               irq;

    int checks = 0;
    int errors = 0;

    irq_event_logger #(
        .NUM_SRC   (NUM_SRC),
        .FIFO_DEPTH(FIFO_DEPTH),
        .TS_WIDTH  (32)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .chipselect(chipselect),
        .address   (address),
        .read_n    (read_n),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .irq_in    (irq_in),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of {src, ts} entries plus the software-visible
    // registers, advanced once per clock from the bus and irq inputs.
    logic [31:0]        m_ts;
    logic [NUM_SRC-1:0] m_dly;
    logic [NUM_SRC-1:0] m_mask;
    logic [NUM_SRC-1:0] m_ev;
    bit                 m_irq_en;
    bit                 m_ovf;
    bit                 m_wr;
    bit                 m_rd;
    logic [15:0]        m_now_h;
    logic [15:0]        m_rdata;
    logic [39:0]        m_q[$];

    function automatic logic [15:0] modelRead(input logic [2:0] a);
        logic [15:0] v;
        v = 16'h0;
        case (a)
            3'd0: v = {8'(m_q.size()), 5'b0, m_ovf, (m_q.size() == FIFO_DEPTH), (m_q.size() != 0)};
            3'd1: v = {7'b0, m_irq_en, 8'(m_mask)};
            3'd2: if (m_q.size() != 0) v = {8'h0, m_q[0][39:32]};
            3'd3: if (m_q.size() != 0) v = m_q[0][15:0];
            3'd4: if (m_q.size() != 0) v = m_q[0][31:16];
            3'd6: v = m_ts[15:0];
            3'd7: v = m_now_h;
            default: v = 16'h0;
        endcase
        return v;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ts = 0; m_dly = 0; m_mask = 0; m_irq_en = 0; m_ovf = 0;
            m_now_h = 0; m_rdata = 0;
            m_q.delete();
        end else begin
            m_rdata = modelRead(address);
            m_wr = chipselect && !write_n;
            m_rd = chipselect && !read_n;
            m_ev = irq_in & ~m_dly & m_mask;
            if (m_wr && address == 3'd0) m_ovf = 0;
            if (m_wr && address == 3'd1 && writedata[9]) begin
                m_q.delete();
            end else begin
                if (m_wr && address == 3'd5 && m_q.size() != 0) m_q.delete(0);
                if (m_ev != 0) begin
                    if (m_q.size() < FIFO_DEPTH) m_q.push_back({8'(m_ev), m_ts});
                    else m_ovf = 1;
                end
            end
            if (m_wr && address == 3'd1) begin
                m_mask   = writedata[NUM_SRC-1:0];
                m_irq_en = writedata[8];
            end
            if (m_rd && address == 3'd6) m_now_h = m_ts[31:16];
            m_dly = irq_in;
            m_ts  = m_ts + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Continuous comparison of the DUT against the model, away from posedge.
    always @(negedge clk) begin
        if (reset_n) begin
            checkOutput("model_readdata", {16'h0, readdata}, {16'h0, m_rdata});
            checkOutput("model_irq", {31'h0, irq}, {31'h0, (m_irq_en && m_q.size() != 0)});
        end
    end

    // One bus cycle: drive at a negedge, advance past one posedge, go idle.
    task automatic applyStimulus(input logic cs, input logic rd, input logic wr,
                                 input logic [2:0] addr, input logic [15:0] data);
        chipselect = cs;
        read_n     = ~rd;
        write_n    = ~wr;
        address    = addr;
        writedata  = data;
        @(negedge clk);
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
    endtask

    task automatic readReg(input logic [2:0] addr, output logic [15:0] value);
        applyStimulus(1'b1, 1'b1, 1'b0, addr, 16'h0);
        value = readdata;
    endtask

    task automatic writeReg(input logic [2:0] addr, input logic [15:0] data);
        applyStimulus(1'b1, 1'b0, 1'b1, addr, data);
    endtask

    task automatic expectReg(input string name, input logic [2:0] addr, input logic [15:0] expected);
        logic [15:0] v;
        readReg(addr, v);
        checkOutput(name, {16'h0, v}, {16'h0, expected});
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitTs(input logic [31:0] target, input int limit);
        int n;
        n = 0;
        while (m_ts != target && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (m_ts != target) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_ts: timed out at 0x%0h, required 0x%0h", m_ts, target);
        end
    endtask

    // Raise and drop irq_in[0] n times, recording each edge's timestamp.
    logic [31:0] exp_ts[$];
    task automatic pushEdges(input int n);
        for (int i = 0; i < n; i++) begin
            exp_ts.push_back(m_ts);
            irq_in[0] = 1'b1;
            @(negedge clk);
            irq_in[0] = 1'b0;
            @(negedge clk);
        end
    endtask

    typedef struct {
        bit          is_write;
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic [15:0] expected;
        string       name;
    } vec_t;
    vec_t vecs[$];

    initial begin
        logic [15:0] lo;
        logic [15:0] hi;
        logic [31:0] ts_new;
        logic [31:0] kept[$];

        chipselect = 0; read_n = 1; write_n = 1; address = 0; writedata = 0;
        irq_in = '0;
        reset_n = 1'b0;
        #1;
        checkOutput("reset_readdata", {16'h0, readdata}, 32'h0);
        checkOutput("reset_irq", {31'h0, irq}, 32'h0);
        idleCycles(2);
        reset_n = 1'b1;

        // Register map vectors from the reset state with all irq lines low.
        vecs.push_back('{0, 3'd0, 16'h0000, 16'h0000, "status_reset"});
        vecs.push_back('{0, 3'd1, 16'h0000, 16'h0000, "control_reset"});
        vecs.push_back('{0, 3'd2, 16'h0000, 16'h0000, "head_src_empty"});
        vecs.push_back('{0, 3'd3, 16'h0000, 16'h0000, "head_ts_l_empty"});
        vecs.push_back('{0, 3'd4, 16'h0000, 16'h0000, "head_ts_h_empty"});
        vecs.push_back('{0, 3'd5, 16'h0000, 16'h0000, "pop_reads_zero"});
        vecs.push_back('{0, 3'd7, 16'h0000, 16'h0000, "now_h_reset"});
        vecs.push_back('{1, 3'd1, 16'h03FF, 16'h0000, ""});
        vecs.push_back('{0, 3'd1, 16'h0000, 16'h010F, "control_mask_width"});
        vecs.push_back('{1, 3'd2, 16'hFFFF, 16'h0000, ""});
        vecs.push_back('{1, 3'd7, 16'hFFFF, 16'h0000, ""});
        vecs.push_back('{0, 3'd1, 16'h0000, 16'h010F, "control_after_ignored"});
        vecs.push_back('{1, 3'd5, 16'h0000, 16'h0000, ""});
        vecs.push_back('{0, 3'd0, 16'h0000, 16'h0000, "status_pop_empty"});
        vecs.push_back('{1, 3'd1, 16'h0000, 16'h0000, ""});
        vecs.push_back('{0, 3'd1, 16'h0000, 16'h0000, "control_cleared"});
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_write) writeReg(vecs[i].addr, vecs[i].wdata);
            else expectReg(vecs[i].name, vecs[i].addr, vecs[i].expected);
        end

        $display("[TB] single event at timestamp 100");
        writeReg(3'd1, 16'h0101);
        waitTs(32'd100, 200);
        irq_in[0] = 1'b1;
        idleCycles(1);
        expectReg("t1_status", 3'd0, 16'h0101);
        checkOutput("t1_irq", {31'h0, irq}, 32'h1);
        expectReg("t1_head_src", 3'd2, 16'h0001);
        expectReg("t1_head_ts_l", 3'd3, 16'h0064);
        expectReg("t1_head_ts_h", 3'd4, 16'h0000);
        writeReg(3'd5, 16'h0);
        expectReg("t1_status_popped", 3'd0, 16'h0000);
        checkOutput("t1_irq_popped", {31'h0, irq}, 32'h0);
        irq_in = '0;

        $display("[TB] simultaneous edges");
        writeReg(3'd1, 16'h000F);
        irq_in = 4'b0110;
        idleCycles(1);
        expectReg("t2_status", 3'd0, 16'h0101);
        expectReg("t2_head_src", 3'd2, 16'h0006);
        checkOutput("t2_irq_disabled", {31'h0, irq}, 32'h0);
        writeReg(3'd5, 16'h0);
        irq_in = '0;
        idleCycles(1);

        $display("[TB] masking and already-high level");
        writeReg(3'd1, 16'h0001);
        irq_in = 4'b0010;
        idleCycles(2);
        expectReg("t3_masked", 3'd0, 16'h0000);
        irq_in = '0;
        writeReg(3'd1, 16'h0000);
        irq_in = 4'b0001;
        idleCycles(1);
        writeReg(3'd1, 16'h0001);
        idleCycles(5);
        expectReg("t3_level_high", 3'd0, 16'h0000);
        irq_in = '0;
        idleCycles(1);
        irq_in = 4'b0001;
        idleCycles(1);
        expectReg("t3_re_rise", 3'd0, 16'h0101);
        writeReg(3'd5, 16'h0);
        irq_in = '0;
        idleCycles(1);

        $display("[TB] overflow and full push+pop");
        exp_ts.delete();
        pushEdges(17);
        expectReg("t4_status_full", 3'd0, 16'h1007);
        for (int i = 0; i < FIFO_DEPTH; i++) kept.push_back(exp_ts[i]);
        writeReg(3'd0, 16'hFFFF);
        expectReg("t4_ovf_cleared", 3'd0, 16'h1003);
        ts_new = m_ts;
        irq_in[0] = 1'b1;
        writeReg(3'd5, 16'h0);
        irq_in[0] = 1'b0;
        kept.delete(0);
        kept.push_back(ts_new);
        expectReg("t4_push_pop_full", 3'd0, 16'h1003);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            readReg(3'd3, lo);
            readReg(3'd4, hi);
            checkOutput($sformatf("t4_order_%0d", i), {hi, lo}, kept[i]);
            writeReg(3'd5, 16'h0);
        end
        expectReg("t4_drained", 3'd0, 16'h0000);

        $display("[TB] flush with simultaneous edge");
        pushEdges(17);
        irq_in[0] = 1'b1;
        writeReg(3'd1, 16'h0201);
        irq_in[0] = 1'b0;
        expectReg("t5_status_flushed", 3'd0, 16'h0004);
        expectReg("t5_control_readback", 3'd1, 16'h0001);
        writeReg(3'd0, 16'h0);
        expectReg("t5_ovf_cleared", 3'd0, 16'h0000);

        $display("[TB] NOW_H shadow across 0x0000FFFF");
        waitTs(32'h0000FFFF, 70000);
        expectReg("t6_now_l", 3'd6, 16'hFFFF);
        idleCycles(2);
        expectReg("t6_now_h_shadow", 3'd7, 16'h0000);
        readReg(3'd6, lo);
        expectReg("t6_now_h_next", 3'd7, 16'h0001);

        $display("[TB] randomized traffic against the model");
        for (int i = 0; i < 3000; i++) begin
            logic [2:0]  a;
            logic [15:0] d;
            int          op;
            if ($urandom_range(0, 3) == 0) irq_in = NUM_SRC'($urandom);
            op = $urandom_range(0, 9);
            a  = 3'($urandom_range(0, 7));
            d  = 16'($urandom);
            if (a == 3'd1 && $urandom_range(0, 7) != 0) d[9] = 1'b0;
            if (i == 1500) begin
                #2 reset_n = 1'b0;
                #1;
                checkOutput("midreset_readdata", {16'h0, readdata}, 32'h0);
                checkOutput("midreset_irq", {31'h0, irq}, 32'h0);
                idleCycles(2);
                reset_n = 1'b1;
            end else if (op < 3) begin
                applyStimulus(1'b1, 1'b1, 1'b0, a, d);
            end else if (op < 6) begin
                if ($urandom_range(0, 1) == 0) a = 3'd5;
                applyStimulus(1'b1, 1'b0, 1'b1, a, d);
            end else if (op == 6) begin
                applyStimulus(1'b1, 1'b1, 1'b1, a, d);
            end else begin
                applyStimulus(1'b0, 1'b1, 1'b1, a, d);
            end
        end
        idleCycles(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
